// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on operand
// magnitudes, followed by a sign-correction cycle that registers the results.
module seq_divider #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    q_d     = q_q;
    r_d     = r_q;

    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];

    // Shifted remainder can exceed WIDTH bits, but the difference fits whenever
    // the subtraction is kept, so only the low WIDTH bits are needed.
    shifted = {rem_q, dvd_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    diff    = shifted[WIDTH-1:0] - dvs_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = '0;
          dvd_d   = a_neg ? -a : a;
          dvs_d   = b_neg ? -b : b;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          zero_d  = (b == '0);
          cnt_d   = CW'(WIDTH);
          state_d = ITER;
        end
      end
      ITER: begin
        dvd_d = {dvd_q[WIDTH-2:0], fits};
        rem_d = fits ? diff : shifted[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // With a zero divisor every trial succeeds, leaving |a| in rem, so the
        // normal remainder sign fix reproduces the original dividend.
        q_d     = zero_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
        r_d     = rneg_q ? -rem_q : rem_q;
        dbz_d   = zero_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, handshake and
// reset behaviour, and random operands against a plain-arithmetic model.
module tb_seq_divider;

  localparam int unsigned W      = 64;
  localparam time         PERIOD = 10;
  localparam int          LAT    = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] q, r;

  int n_vec = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  always #(PERIOD / 2) clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: language-level division with the documented special cases.
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn,
                                  output logic [W-1:0] eq, output logic [W-1:0] er,
                                  output logic ez);
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    ez = (y == '0);
    if (ez) begin
      eq = '1;
      er = x;
    end else if (!sgn) begin
      eq = x / y;
      er = x % y;
    end else if (x == 64'h8000_0000_0000_0000 && sy == -64'sd1) begin
      eq = x;
      er = '0;
    end else begin
      eq = sx / sy;
      er = sx % sy;
    end
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
    @(negedge clk);
    a = x;
    b = y;
    is_signed = sgn;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    is_signed = ~sgn;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    check_eq("done_low_after_start", 64'(done), 64'd0);
  endtask

  task automatic wait_done(output int cycles);
    int n = 0;
    int gaps = 0;
    while (done !== 1'b1 && n < 4 * LAT) begin
      if (busy !== 1'b1) gaps++;
      @(posedge clk);
      #1;
      n++;
    end
    cycles = n;
    check_eq("done_seen", 64'(done), 64'd1);
    check_eq("busy_held", 64'(gaps), 64'd0);
    check_eq("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
    int n;
    logic [W-1:0] eq, er;
    logic ez;
    start_op(x, y, sgn);
    wait_done(n);
    ref_div(x, y, sgn, eq, er, ez);
    check_eq("latency", 64'(n), 64'(LAT));
    check_eq("q", q, eq);
    check_eq("r", r, er);
    check_eq("dbz", 64'(div_by_zero), 64'(ez));
    if (!ez) check_eq("invariant", q * y + r, x);
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    run_op(x, y, sgn);
    check_eq("dir_q", q, eq);
    check_eq("dir_r", r, er);
    check_eq("dir_dbz", 64'(div_by_zero), 64'(ez));
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v = v >> $urandom_range(0, 63);
      1: v = 64'($urandom_range(0, 20));
      2: v = -64'($urandom_range(0, 20));
      3: v = 64'h8000_0000_0000_0000;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    int n;
    logic [W-1:0] x, y;

    reset = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_q", q, '0);
    check_eq("rst_r", r, '0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Back-to-back: each start lands in the previous done cycle.
    directed(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);
    directed(-64'd7, 64'd2, 1'b1, -64'd3, -64'd1, 1'b0);
    directed(64'd7, -64'd2, 1'b1, -64'd3, 64'd1, 1'b0);
    directed(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 1'b0);
    directed(64'h8000_0000_0000_0000, -64'd1, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 1'b0);
    directed(64'h8000_0000_0000_0000, -64'd1, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 1'b0);
    directed(64'd5, 64'd0, 1'b0, '1, 64'd5, 1'b1);
    directed(64'd5, 64'd0, 1'b1, '1, 64'd5, 1'b1);
    directed(-64'd5, 64'd0, 1'b1, '1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    directed(-64'd5, 64'd0, 1'b0, '1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);

    // Start while busy must be ignored.
    start_op(64'd1000, 64'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 64'd77;
    b = 64'd5;
    is_signed = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check_eq("ignored_latency", 64'(10 + n), 64'(LAT));
    check_eq("ignored_q", q, 64'd333);
    check_eq("ignored_r", r, 64'd1);
    @(posedge clk);
    #1;
    check_eq("done_single_cycle", 64'(done), 64'd0);
    check_eq("q_stable", q, 64'd333);
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_no_done", 64'(done), 64'd0);

    // Reset in the middle of an operation.
    start_op(64'd12345, 64'd11, 1'b0);
    repeat (29) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_q", q, '0);
    check_eq("midrst_r", r, '0);
    check_eq("midrst_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("inrst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("postrst_done", 64'(done), 64'd0);
    check_eq("postrst_busy", 64'(busy), 64'd0);
    directed(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 300; i++) begin
        x = rnd_operand();
        y = rnd_operand();
        if (y == '0) y = 64'd1;
        run_op(x, y, m[0]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
